// File: rtl/mult_pkg.sv
// Shared constants and row types for the multiplier partial-product pipeline.
package mult_pkg;

    localparam int BITWIDTH_DEF = 8;
    localparam int ACCW_DEF     = 32;

    // Full-width row (sum row, carry row, product) and half-width row.
    typedef logic [2*BITWIDTH_DEF-1:0] row_t;
    typedef logic [BITWIDTH_DEF-1:0]   half_t;

endpackage

// File: rtl/pp_final_cpa_pipe_cpa_slice.sv
// Combinational W-bit ripple/carry-propagate adder slice with carry-in and carry-out.
module cpa_slice
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/pp_final_cpa_pipe.sv
// Final carry-propagate adder for the reduced partial-product rows, split over two
// pipeline stages (low half, then high half), with error statistics against a
// supplied exact product for scoring approximate compressor configurations.
module pp_final_cpa_pipe
    import mult_pkg::*;
#(
    parameter int Bitwidth = BITWIDTH_DEF,
    parameter int AccW     = ACCW_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*Bitwidth-1:0] pp1,
    input  logic [2*Bitwidth-1:0] pp2,
    input  logic [2*Bitwidth-1:0] exact_prod,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*Bitwidth-1:0] product,
    output logic [2*Bitwidth-1:0] err_dist,
    input  logic                  stats_clr,
    output logic [AccW-1:0]       sample_cnt,
    output logic [AccW-1:0]       err_cnt,
    output logic [AccW-1:0]       err_sum
);

    localparam int B  = Bitwidth;
    localparam int RW = 2 * Bitwidth;

    // Add that sticks at all-ones instead of wrapping.
    function automatic logic [AccW-1:0] sat_add(input logic [AccW-1:0] a,
                                                input logic [AccW-1:0] b);
        logic [AccW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[AccW] ? {AccW{1'b1}} : s[AccW-1:0];
    endfunction

    // Unsigned absolute difference.
    function automatic logic [RW-1:0] abs_diff(input logic [RW-1:0] a,
                                               input logic [RW-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Stage 1 registers: low half sum, its carry, the untouched high halves.
    logic          vld_p1;
    logic [B-1:0]  lo_p1;
    logic          cy_p1;
    logic [B-1:0]  pp1_hi_p1;
    logic [B-1:0]  pp2_hi_p1;
    logic [RW-1:0] exact_p1;

    // Stage 2 registers: final product and its distance from the exact product.
    logic          vld_p2;
    logic [RW-1:0] product_p2;
    logic [RW-1:0] err_dist_p2;

    logic [AccW-1:0] sample_cnt_q;
    logic [AccW-1:0] err_cnt_q;
    logic [AccW-1:0] err_sum_q;

    logic          s1_load;
    logic          s2_load;
    logic          out_hs;
    logic [B-1:0]  lo_sum;
    logic          lo_cout;
    logic [B-1:0]  hi_sum;
    logic          hi_cout_unused;
    logic          pp2_msb_unused;
    logic [RW-1:0] prod_nxt;
    logic [RW-1:0] dist_nxt;

    // The carry row has weight 2, so its top bit falls off the modulo-2^(2B) product.
    assign pp2_msb_unused = pp2[RW-1];

    assign s2_load  = vld_p1 && (!vld_p2 || out_ready);
    assign in_ready = !vld_p1 || s2_load;
    assign s1_load  = in_valid && in_ready;
    assign out_hs   = vld_p2 && out_ready;

    // ---- stage 0 -> 1: low half of pp1 + (pp2 << 1) ----
    cpa_slice #(.W(B)) u_cpa_lo (
        .a    (pp1[B-1:0]),
        .b    ({pp2[B-2:0], 1'b0}),
        .cin  (1'b0),
        .sum  (lo_sum),
        .cout (lo_cout)
    );

    // Stage 1 valid: filled on input handshake, emptied when stage 2 takes the beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (s1_load) begin
            vld_p1 <= 1'b1;
        end else if (s2_load) begin
            vld_p1 <= 1'b0;
        end
    end

    // Stage 1 data: captured only on accept; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (s1_load) begin
            lo_p1     <= lo_sum;
            cy_p1     <= lo_cout;
            pp1_hi_p1 <= pp1[RW-1:B];
            pp2_hi_p1 <= pp2[RW-2:B-1];
            exact_p1  <= exact_prod;
        end
    end

    // ---- stage 1 -> 2: high half with the registered low-half carry ----
    cpa_slice #(.W(B)) u_cpa_hi (
        .a    (pp1_hi_p1),
        .b    (pp2_hi_p1),
        .cin  (cy_p1),
        .sum  (hi_sum),
        .cout (hi_cout_unused)
    );

    assign prod_nxt = {hi_sum, lo_p1};
    assign dist_nxt = abs_diff(prod_nxt, exact_p1);

    // Output stage: load a new result or drain on consumer accept; hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2      <= 1'b0;
            product_p2  <= '0;
            err_dist_p2 <= '0;
        end else if (s2_load) begin
            vld_p2      <= 1'b1;
            product_p2  <= prod_nxt;
            err_dist_p2 <= dist_nxt;
        end else if (out_ready) begin
            vld_p2      <= 1'b0;
        end
    end

    // Error statistics on each delivered result; a coincident clear discards that sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            err_sum_q    <= '0;
        end else if (stats_clr) begin
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            err_sum_q    <= '0;
        end else if (out_hs) begin
            sample_cnt_q <= sat_add(sample_cnt_q, AccW'(1));
            err_cnt_q    <= sat_add(err_cnt_q, AccW'(err_dist_p2 != '0));
            err_sum_q    <= sat_add(err_sum_q, AccW'(err_dist_p2));
        end
    end

    assign out_valid  = vld_p2;
    assign product    = product_p2;
    assign err_dist   = err_dist_p2;
    assign sample_cnt = sample_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign err_sum    = err_sum_q;

endmodule

// File: tb/tb_pp_final_cpa_pipe.sv
// Directed bench for pp_final_cpa_pipe: a Bitwidth=8/AccW=32 instance for the
// datapath and flow control, and an AccW=4 instance for counter saturation.
module tb_pp_final_cpa_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, stats_clr;
    logic [15:0] pp1, pp2, exact_prod, product, err_dist;
    logic [31:0] sample_cnt, err_cnt, err_sum;

    logic        in_valid_s, in_ready_s, out_valid_s, out_ready_s, stats_clr_s;
    logic [15:0] pp1_s, pp2_s, exact_s, product_s, err_dist_s;
    logic [3:0]  sample_cnt_s, err_cnt_s, err_sum_s;

    pp_final_cpa_pipe #(.Bitwidth(8), .AccW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .pp1(pp1), .pp2(pp2), .exact_prod(exact_prod),
        .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .err_dist(err_dist),
        .stats_clr(stats_clr),
        .sample_cnt(sample_cnt), .err_cnt(err_cnt), .err_sum(err_sum)
    );

    pp_final_cpa_pipe #(.Bitwidth(8), .AccW(4)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_s), .in_ready(in_ready_s),
        .pp1(pp1_s), .pp2(pp2_s), .exact_prod(exact_s),
        .out_valid(out_valid_s), .out_ready(out_ready_s),
        .product(product_s), .err_dist(err_dist_s),
        .stats_clr(stats_clr_s),
        .sample_cnt(sample_cnt_s), .err_cnt(err_cnt_s), .err_sum(err_sum_s)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 0; pp1 = 0; pp2 = 0; exact_prod = 0; out_ready = 0; stats_clr = 0;
        in_valid_s = 0; pp1_s = 0; pp2_s = 0; exact_s = 0; out_ready_s = 1; stats_clr_s = 0;
        repeat (2) step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (product !== 16'h0) begin errors++; $display("FAIL reset_product: got %h want 0000", product); end
        checks++; if (err_dist !== 16'h0) begin errors++; $display("FAIL reset_err_dist: got %h want 0000", err_dist); end
        checks++; if (sample_cnt !== 32'd0) begin errors++; $display("FAIL reset_sample_cnt: got %0d want 0", sample_cnt); end
        checks++; if (err_cnt !== 32'd0) begin errors++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
        checks++; if (err_sum !== 32'd0) begin errors++; $display("FAIL reset_err_sum: got %0d want 0", err_sum); end
        rst_n = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        out_ready = 1;
        in_valid = 1; pp1 = 16'h0100; pp2 = 16'h0080; exact_prod = 16'h0200;
        step();
        in_valid = 0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_latency1: out_valid got %b want 0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid: got %b want 1", out_valid); end
        checks++; if (product !== 16'h0200) begin errors++; $display("FAIL basic_product: got %h want 0200", product); end
        checks++; if (err_dist !== 16'h0) begin errors++; $display("FAIL basic_err_dist: got %h want 0000", err_dist); end
        step();
        checks++; if (sample_cnt !== 32'd1) begin errors++; $display("FAIL basic_sample_cnt: got %0d want 1", sample_cnt); end
        checks++; if (err_cnt !== 32'd0) begin errors++; $display("FAIL basic_err_cnt: got %0d want 0", err_cnt); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_carry_wrap();
        out_ready = 1;
        in_valid = 1; pp1 = 16'h0080; pp2 = 16'h0040; exact_prod = 16'h0100;
        step();
        pp1 = 16'hFFFF; pp2 = 16'h8001; exact_prod = 16'h0001;
        step();
        in_valid = 0;
        checks++; if (product !== 16'h0100) begin errors++; $display("FAIL carry_product: got %h want 0100", product); end
        checks++; if (err_dist !== 16'h0) begin errors++; $display("FAIL carry_err_dist: got %h want 0000", err_dist); end
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL wrap_out_valid: got %b want 1", out_valid); end
        checks++; if (product !== 16'h0001) begin errors++; $display("FAIL wrap_product: got %h want 0001", product); end
        step();
        checks++; if (sample_cnt !== 32'd3) begin errors++; $display("FAIL carry_sample_cnt: got %0d want 3", sample_cnt); end
    endtask

    task automatic test_error_stats();
        out_ready = 1;
        stats_clr = 1;
        step();
        stats_clr = 0;
        checks++; if (sample_cnt !== 32'd0) begin errors++; $display("FAIL clr_sample_cnt: got %0d want 0", sample_cnt); end
        in_valid = 1; pp1 = 16'h00FF; pp2 = 16'h0001; exact_prod = 16'h0104;
        step();
        pp1 = 16'h0010; pp2 = 16'h0000; exact_prod = 16'h000C;
        step();
        in_valid = 0;
        checks++; if (product !== 16'h0101) begin errors++; $display("FAIL err1_product: got %h want 0101", product); end
        checks++; if (err_dist !== 16'd3) begin errors++; $display("FAIL err1_err_dist: got %0d want 3", err_dist); end
        step();
        checks++; if (err_cnt !== 32'd1) begin errors++; $display("FAIL err1_err_cnt: got %0d want 1", err_cnt); end
        checks++; if (err_sum !== 32'd3) begin errors++; $display("FAIL err1_err_sum: got %0d want 3", err_sum); end
        checks++; if (product !== 16'h0010) begin errors++; $display("FAIL err2_product: got %h want 0010", product); end
        checks++; if (err_dist !== 16'd4) begin errors++; $display("FAIL err2_err_dist: got %0d want 4", err_dist); end
        step();
        checks++; if (err_cnt !== 32'd2) begin errors++; $display("FAIL err2_err_cnt: got %0d want 2", err_cnt); end
        checks++; if (err_sum !== 32'd7) begin errors++; $display("FAIL err2_err_sum: got %0d want 7", err_sum); end
        checks++; if (sample_cnt !== 32'd2) begin errors++; $display("FAIL err2_sample_cnt: got %0d want 2", sample_cnt); end
    endtask

    task automatic test_backpressure();
        logic [15:0] vals [4];
        int sent = 0;
        int rcv  = 0;
        int cyc  = 0;
        logic hs_in;
        vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333; vals[3] = 16'h4444;
        stats_clr = 1;
        step();
        stats_clr = 0;
        pp2 = 16'h0000;
        while (rcv < 4 && cyc < 30) begin
            in_valid   = (sent < 4);
            pp1        = vals[sent < 4 ? sent : 3];
            exact_prod = pp1 + 16'd1;
            out_ready  = (cyc >= 5);
            #1;
            hs_in = in_valid && in_ready;
            if (cyc >= 2 && cyc <= 4) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready c%0d: got %b want 0", cyc, in_ready); end
                checks++; if (product !== vals[0]) begin errors++; $display("FAIL bp_hold c%0d: got %h want %h", cyc, product, vals[0]); end
            end
            if (cyc == 4) begin
                checks++; if (sent != 2) begin errors++; $display("FAIL bp_accepted: got %0d want 2", sent); end
            end
            if (out_valid && out_ready) begin
                checks++; if (product !== vals[rcv]) begin errors++; $display("FAIL bp_order %0d: got %h want %h", rcv, product, vals[rcv]); end
                rcv++;
            end
            step();
            if (hs_in) sent++;
            cyc++;
        end
        in_valid = 0;
        checks++; if (rcv != 4) begin errors++; $display("FAIL bp_received: got %0d want 4 (cycle budget)", rcv); end
        checks++; if (sample_cnt !== 32'd4) begin errors++; $display("FAIL bp_sample_cnt: got %0d want 4", sample_cnt); end
        checks++; if (err_sum !== 32'd4) begin errors++; $display("FAIL bp_err_sum: got %0d want 4", err_sum); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_saturation();
        out_ready_s = 1;
        pp2_s = 16'h0000;
        for (int k = 1; k <= 20; k++) begin
            in_valid_s = 1; pp1_s = 16'(k); exact_s = 16'(k + 1);
            step();
        end
        in_valid_s = 0;
        repeat (3) step();
        checks++; if (sample_cnt_s !== 4'd15) begin errors++; $display("FAIL sat_sample_cnt: got %0d want 15", sample_cnt_s); end
        checks++; if (err_cnt_s !== 4'd15) begin errors++; $display("FAIL sat_err_cnt: got %0d want 15", err_cnt_s); end
        checks++; if (err_sum_s !== 4'd15) begin errors++; $display("FAIL sat_err_sum: got %0d want 15", err_sum_s); end
        in_valid_s = 1; pp1_s = 16'h0050; exact_s = 16'h0057;
        step();
        in_valid_s = 0;
        step();
        checks++; if (product_s !== 16'h0050) begin errors++; $display("FAIL clr_product: got %h want 0050", product_s); end
        checks++; if (err_dist_s !== 16'd7) begin errors++; $display("FAIL clr_err_dist: got %0d want 7", err_dist_s); end
        stats_clr_s = 1;
        step();
        stats_clr_s = 0;
        checks++; if (sample_cnt_s !== 4'd0) begin errors++; $display("FAIL clr_hs_sample_cnt: got %0d want 0", sample_cnt_s); end
        checks++; if (err_cnt_s !== 4'd0) begin errors++; $display("FAIL clr_hs_err_cnt: got %0d want 0", err_cnt_s); end
        checks++; if (err_sum_s !== 4'd0) begin errors++; $display("FAIL clr_hs_err_sum: got %0d want 0", err_sum_s); end
    endtask

    task automatic test_reset_midstream();
        out_ready = 0;
        pp2 = 16'h0000;
        in_valid = 1; pp1 = 16'h0A0A; exact_prod = 16'h0A0B;
        step();
        pp1 = 16'h0B0B; exact_prod = 16'h0B0B;
        step();
        in_valid = 0;
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_full: out_valid=%b in_ready=%b want 1/0", out_valid, in_ready); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
        checks++; if (product !== 16'h0) begin errors++; $display("FAIL mid_product: got %h want 0000", product); end
        checks++; if (sample_cnt !== 32'd0 || err_cnt !== 32'd0 || err_sum !== 32'd0) begin
            errors++; $display("FAIL mid_counters: got %0d/%0d/%0d want 0/0/0", sample_cnt, err_cnt, err_sum);
        end
        step();
        rst_n = 1'b1;
        step();
        out_ready = 1;
        in_valid = 1; pp1 = 16'h0C0C; exact_prod = 16'h0C0C;
        step();
        in_valid = 0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_stale: out_valid got %b want 0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_new_valid: got %b want 1", out_valid); end
        checks++; if (product !== 16'h0C0C) begin errors++; $display("FAIL mid_new_product: got %h want 0c0c", product); end
        step();
        checks++; if (sample_cnt !== 32'd1) begin errors++; $display("FAIL mid_new_count: got %0d want 1", sample_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_wrap();
        test_error_stats();
        test_backpressure();
        test_saturation();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
